// File: rtl/reset_seq_pkg.sv
// +-----------------------------------------------------------------------+
// | reset_seq_pkg : shared state type and default sizing for the sequencer |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
`default_nettype none

package reset_seq_pkg;

  localparam int c_NUM_CH   = 2;
  localparam int c_CNT_W    = 21;
  localparam int c_HOLD_CYC = 8;

  typedef enum logic [1:0] {
    ST_HOLD  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } seq_state_t;

  // Index width that stays legal for a single channel
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/reset_sequencer_if.sv
// +-----------------------------------------------------------------------+
// | reset_sequencer_if : control/status bundle of the reset sequencer      |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
`default_nettype none

interface reset_sequencer_if
  import reset_seq_pkg::*;
#(
  parameter int NUM_CH = c_NUM_CH,
  parameter int CNT_W  = c_CNT_W
);

  logic                    ext_rst_n;
  logic                    seq_mode;
  logic [NUM_CH*CNT_W-1:0] ch_delay;
  logic [NUM_CH-1:0]       sw_rst_req;
  logic [NUM_CH-1:0]       ch_rst_n;
  logic [NUM_CH-1:0]       ch_done;
  logic                    seq_busy;
  logic                    seq_done;

  modport master (
    output ext_rst_n, seq_mode, ch_delay, sw_rst_req,
    input  ch_rst_n, ch_done, seq_busy, seq_done
  );

  modport slave (
    input  ext_rst_n, seq_mode, ch_delay, sw_rst_req,
    output ch_rst_n, ch_done, seq_busy, seq_done
  );

endinterface

`default_nettype wire

// File: rtl/reset_sync_2ff.sv
// +-----------------------------------------------------------------------+
// | reset_sync_2ff : two-flop synchronizer for the board reset request     |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
`default_nettype none

module reset_sync_2ff (
  input  wire logic clk_125,
  input  wire logic sys_rst,
  input  wire logic i_async,
  output logic      o_sync
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk_125) begin
    if (sys_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

`default_nettype wire

// File: rtl/reset_sequencer.sv
// +-----------------------------------------------------------------------+
// | reset_sequencer : staged release of per-channel resets + SW re-reset   |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
`default_nettype none

module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_CH   = c_NUM_CH,
  parameter int CNT_W    = c_CNT_W,
  parameter int HOLD_CYC = c_HOLD_CYC
) (
  input  wire logic          clk_125,
  input  wire logic          sys_rst,
  reset_sequencer_if.slave   io_bus
);

  localparam int              IDX_W   = clog2_min1(NUM_CH);
  localparam int              HLD_W   = $clog2(HOLD_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic w_sync_rst_n;

  reset_sync_2ff u_sync (
    .clk_125 (clk_125),
    .sys_rst (sys_rst),
    .i_async (io_bus.ext_rst_n),
    .o_sync  (w_sync_rst_n)
  );

  seq_state_t        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [IDX_W-1:0]  r_idx;
  logic              r_mode;
  logic [CNT_W-1:0]  r_dly  [NUM_CH];
  logic [HLD_W-1:0]  r_hold [NUM_CH];
  logic [NUM_CH-1:0] r_ch_rst_n;
  logic [NUM_CH-1:0] r_ch_done;
  logic              r_busy;
  logic              r_done;

  logic [NUM_CH-1:0] w_hit;
  logic [NUM_CH-1:0] w_seq_mask;
  logic              w_seq_hit;
  logic [NUM_CH-1:0] w_rel_next;
  logic [CNT_W-1:0]  w_cnt_inc;

  always_comb begin
    w_hit      = '0;
    w_seq_mask = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_hit[i]      = (r_cnt == r_dly[i]);
      w_seq_mask[i] = (r_idx == IDX_W'(i));
    end
    w_seq_hit  = |(w_hit & w_seq_mask);
    w_rel_next = r_mode ? (r_ch_rst_n | (w_seq_mask & {NUM_CH{w_seq_hit}}))
                        : (r_ch_rst_n | w_hit);
    // Saturate so an all-ones delay is still matched rather than skipped by a wrap
    w_cnt_inc  = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk_125) begin
    if (sys_rst) begin
      r_state    <= ST_HOLD;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_mode     <= 1'b0;
      r_ch_rst_n <= '0;
      r_ch_done  <= '0;
      r_busy     <= 1'b1;
      r_done     <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_dly[i]  <= '0;
        r_hold[i] <= '0;
      end
    end else if (!w_sync_rst_n) begin
      r_state    <= ST_HOLD;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_ch_rst_n <= '0;
      r_ch_done  <= '0;
      r_busy     <= 1'b1;
      r_done     <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_hold[i] <= '0;
      end
    end else begin
      case (r_state)
        ST_HOLD: begin
          r_state <= ST_COUNT;
          r_cnt   <= '0;
          r_idx   <= '0;
          r_mode  <= io_bus.seq_mode;
          for (int i = 0; i < NUM_CH; i++) begin
            r_dly[i] <= io_bus.ch_delay[i*CNT_W +: CNT_W];
          end
        end
        ST_COUNT: begin
          r_ch_rst_n <= w_rel_next;
          r_ch_done  <= w_rel_next;
          if (r_mode && w_seq_hit) begin
            r_cnt <= '0;
            r_idx <= r_idx + IDX_W'(1);
          end else begin
            r_cnt <= w_cnt_inc;
          end
          if (&w_rel_next) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          for (int i = 0; i < NUM_CH; i++) begin
            if (io_bus.sw_rst_req[i]) begin
              r_hold[i]     <= HLD_W'(HOLD_CYC);
              r_ch_rst_n[i] <= 1'b0;
              r_ch_done[i]  <= 1'b0;
            end else if (r_hold[i] != '0) begin
              r_hold[i] <= r_hold[i] - HLD_W'(1);
              if (r_hold[i] == HLD_W'(1)) begin
                r_ch_rst_n[i] <= 1'b1;
                r_ch_done[i]  <= 1'b1;
              end
            end
          end
        end
        default: begin
          r_state <= ST_HOLD;
        end
      endcase
    end
  end

  assign io_bus.ch_rst_n = r_ch_rst_n;
  assign io_bus.ch_done  = r_ch_done;
  assign io_bus.seq_busy = r_busy;
  assign io_bus.seq_done = r_done;

endmodule

`default_nettype wire

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 NUM_CH, 2, number of reset channels (1..8).
REQ-002 CNT_W, 21, width of the delay counter and of each per-channel delay field.
REQ-003 HOLD_CYC, 8, assertion width in cycles for a software re-reset (minimum 1).
REQ-004 clk_125  in  1  sole clock; all logic in this domain.
REQ-005 sys_rst  in  1  synchronous, active-high reset.
REQ-006 ext_rst_n  in  1  asynchronous board/PERST reset request, active-low; passes through a 2-flop synchronizer.
REQ-007 seq_mode  in  1  0 = parallel release, 1 = sequential release; sampled on the HOLD->COUNT transition.
REQ-008 ch_delay  in  NUM_CH*CNT_W  per-channel delay; field i = bits [i*CNT_W +: CNT_W]; latched on the HOLD->COUNT transition.
REQ-009 sw_rst_req  in  NUM_CH  one-cycle pulse per channel requesting a re-reset.
REQ-010 ch_rst_n  out  NUM_CH  registered active-low channel resets.
REQ-011 ch_done  out  NUM_CH  channel i released and not in re-reset.
REQ-012 seq_busy  out  1  high in HOLD and COUNT.
REQ-013 seq_done  out  1  high in DONE.

Function
REQ-014 FSM states: HOLD, COUNT, DONE.
REQ-015 HOLD: all ch_rst_n = 0, counter = 0, index = 0; go to COUNT on the first cycle the synchronized ext_rst_n is 1.
REQ-016 COUNT entry cycle T0: counter = 0; delays and mode are latched.
REQ-017 Sequential mode, release rule: when counter == latched delay[idx], ch_rst_n[idx] goes 1 in the next cycle.
REQ-018 Sequential mode, advance rule: on that release the counter clears and idx increments; channel 0 is high at T0+D0+1 and channel 1 at T0+D0+D1+2.
REQ-019 Parallel mode: a single counter runs; ch_rst_n[i] goes 1 the cycle after counter == D[i] (at T0+D[i]+1); released channels stay high.
REQ-020 The counter saturates at all-ones and never wraps; a delay of all-ones is still reached and released.
REQ-021 A delay of 0 releases the channel at T0+1 (parallel) or one cycle after the previous release (sequential).
REQ-022 COUNT->DONE in the same cycle the last channel's ch_rst_n goes 1.
REQ-023 DONE, re-reset: sw_rst_req[i] pulls ch_rst_n[i] low the next cycle, holds it low HOLD_CYC cycles, then releases it; ch_done[i] is low for the same window.
REQ-024 DONE, repeated requests: a further sw_rst_req[i] during the hold window restarts that channel's hold count; channels are independent.
REQ-025 sw_rst_req is ignored in HOLD and COUNT.
REQ-026 A synchronized ext_rst_n = 0 in any state goes to HOLD next cycle; all ch_rst_n are 0 one cycle later; pending hold counts are cleared.
REQ-027 If ext_rst_n deasserts and reasserts mid-COUNT, the sequence restarts from T0 with newly latched delays.
REQ-028 seq_busy and seq_done are registered and mutually exclusive.

Reset
REQ-029 sys_rst = 1: state HOLD, ch_rst_n = all 0, ch_done = 0, seq_busy = 1, seq_done = 0, counters and index = 0, synchronizer flops = 0.
REQ-030 sys_rst has priority over ext_rst_n and sw_rst_req.

Structure
REQ-031 Package reset_seq_pkg holds the state enum and the default constants for NUM_CH, CNT_W and HOLD_CYC.
REQ-032 The ext_rst_n synchronizer is the one sub-module: reset_sync_2ff, 2 flops, clears to 0 on sys_rst.

Verification
REQ-033 NUM_CH=2, seq_mode=1, D0=3, D1=5, ext_rst_n rises -> ch_rst_n[0]=1 at T0+4, ch_rst_n[1]=1 at T0+10, seq_done=1 at T0+10.
REQ-034 seq_mode=0, D0=7, D1=2 -> ch_rst_n[1]=1 at T0+3, ch_rst_n[0]=1 at T0+8, seq_done=1 at T0+8.
REQ-035 In DONE, HOLD_CYC=8, sw_rst_req[1] pulse -> ch_rst_n[1] low 8 cycles then high; ch_rst_n[0] stays 1.
REQ-036 Second sw_rst_req[1] 4 cycles into the hold window -> total low time 12 cycles.
REQ-037 ext_rst_n low at T0+2 with D0=3 -> state HOLD, all ch_rst_n remain 0; on re-rise with D0=0 -> ch_rst_n[0]=1 at T0'+1.
REQ-038 CNT_W=4, D0=15, parallel -> release at T0+16 with no counter wrap; sys_rst pulse in DONE -> all ch_rst_n = 0 next cycle.
